bnn_serial_tx: RTL and testbench
================================

// Module: bnn_serial_tx
// PURPOSE
// - Transmit-side counterpart of the chip's 3-flop input synchronizer.
// - Serializes a parallel word (e.g. classified digit / score) onto one output line.
// - An external receiver samples the line asynchronously through its own 3-stage synchronizer.
// - Every bit is held for BIT_CYCLES clocks so it survives that synchronizer.
// - Sits between the BNN result logic (valid/ready source) and an output pin.
// PARAMETERS
// - DATA_W     default 8 : payload bits per frame (>=1)
// - BIT_CYCLES default 4 : clocks each serial bit is held (>=4, covers 3-flop sync + margin)
// - STOP_BITS  default 1 : number of stop-bit periods (>=1)
// PORTS
// - clk       in   1       : single clock, all logic rising-edge
// - reset     in   1       : synchronous, active-high reset
// - tx_data   in   DATA_W  : payload, sampled only on handshake
// - tx_valid  in   1       : source has a word
// - tx_ready  out  1       : block can accept a word (high only in IDLE)
// - ser_out   out  1       : serial line, registered, idle level 0
// - ser_busy  out  1       : high from the cycle after handshake until frame end
// - tx_done   out  1       : 1-cycle pulse on the last cycle of the final stop period
// BEHAVIOUR
// - Reset (reset=1 at posedge):
//   - state=IDLE, ser_out=0, ser_busy=0, tx_done=0, tx_ready=1 the following cycle.
//   - Counters and shift register are cleared.
// - Handshake: accept when tx_valid && tx_ready at a posedge.
//   - tx_data is latched into the shift register and even parity (^tx_data) is computed.
//   - Later changes to tx_data are ignored until the next handshake.
// - Frame on ser_out (each field held BIT_CYCLES clocks), fields in order:
//   1. START = 1
//   2. DATA_W data bits, MSB first
//   3. PARITY = XOR of the data bits (even parity)
//   4. STOP = 0, held STOP_BITS*BIT_CYCLES clocks
// - FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   - A bit-period counter runs 0..BIT_CYCLES-1.
//   - The bit index runs DATA_W-1..0 in DATA.
//   - The stop counter runs 0..STOP_BITS-1.
//   - The state advances when the bit-period counter wraps from BIT_CYCLES-1 to 0.
// - Latency:
//   - The handshake at edge N makes ser_out=1 (START) starting edge N+1.
//   - Frame length = (DATA_W+2+STOP_BITS)*BIT_CYCLES clocks.
// - tx_done is high for exactly the last STOP clock. The next edge returns the FSM to IDLE.
// - Back-to-back frames:
//   - tx_ready is high in IDLE only, so each frame is followed by at least 1 IDLE clock with ser_out=0.
//   - If tx_valid is held high, the next handshake occurs in that IDLE clock.
// - tx_valid deasserting while tx_ready=0 has no effect; the frame in flight always completes.
// - Reset mid-frame aborts the frame: ser_out=0 at the next edge, no tx_done, and the word is lost.
// - tx_ready is combinational from state only (no dependence on tx_valid).
// - ser_out, ser_busy and tx_done are all registered.
// TESTING (DATA_W=8, BIT_CYCLES=4, STOP_BITS=1, frame = 44 clocks)
// 1. Hold reset 3 cycles mid-idle:
//    - Required: ser_out=0, ser_busy=0, tx_done=0, tx_ready=1 after release.
// 2. Send 0xA5:
//    - ser_out pattern = 1, 1,0,1,0,0,1,0,1, 0, 0; each bit held 4 clocks.
//    - Parity bit = 0.
//    - tx_done pulses at clock 44 after the handshake.
// 3. Send 0x01:
//    - Parity bit = 1.
//    - Data bits are seven 0s then a 1, with the 1 in clocks 33-36 after the handshake.
// 4. Hold tx_valid=1 with 0xFF then 0x00:
//    - Exactly 1 idle clock (ser_out=0, tx_ready=1) separates the frames.
//    - Second frame parity = 0.
// 5. Change tx_data to 0x00 mid-frame after latching 0xC3:
//    - The transmitted bits remain 0xC3 (parity 0).
// 6. Assert reset at clock 20 of a frame:
//    - ser_out=0 and tx_ready=1 after release; no tx_done.
//    - The next 0x5A frame transmits correctly.
// - Bench also runs a model receiver: a 3-flop synchronizer plus mid-bit sampler.
//   - It must recover every word sent, with the ser_out toggle phase swept against its sample points.

Source files
------------

// File: rtl/bnn_serial_tx_if.sv
// Valid/ready handshake that hands one result word to the serial transmitter.
interface bnn_serial_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bnn_serial_tx.sv
// Serial transmitter: frames a word as START(1), data MSB first, even parity,
// STOP(0), each field stretched over BIT_CYCLES clocks so an asynchronous
// receiver behind a 3-flop synchronizer can sample it mid-bit.
module bnn_serial_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic           clk,
   input  logic           reset,
   bnn_serial_tx_if.slave s_tx,
   output logic           ser_out,
   output logic           ser_busy,
   output logic           tx_done
);

   localparam int BC_W  = $clog2(BIT_CYCLES);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int SB_W  = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [SB_W-1:0]  SB_LAST  = SB_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic f_even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   state_t            r_state;
   logic [BC_W-1:0]   r_bit;
   logic [IDX_W-1:0]  r_idx;
   logic [SB_W-1:0]   r_stop;
   logic [DATA_W-1:0] r_shift;
   logic              r_par;
   logic              r_ser;
   logic              r_busy;
   logic              r_done;

   state_t            w_state_nxt;
   logic [BC_W-1:0]   w_bit_nxt;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [SB_W-1:0]   w_stop_nxt;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              w_par_nxt;
   logic              w_ser_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_wrap;
   logic              w_accept;

   // Ready depends on state alone so the source never sees a combinational loop.
   assign s_tx.tx_ready = (r_state == S_IDLE);
   assign w_accept      = s_tx.tx_valid && (r_state == S_IDLE);
   assign w_wrap        = (r_bit == BC_LAST);

   assign ser_out  = r_ser;
   assign ser_busy = r_busy;
   assign tx_done  = r_done;

   // State, counters, latched word and registered line outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_bit   <= '0;
         r_idx   <= '0;
         r_stop  <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_ser   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bit   <= w_bit_nxt;
         r_idx   <= w_idx_nxt;
         r_stop  <= w_stop_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_ser   <= w_ser_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next state: every field advances when the bit-period counter wraps.
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      w_idx_nxt   = r_idx;
      w_stop_nxt  = r_stop;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      if (r_state != S_IDLE) begin
         w_bit_nxt = w_wrap ? '0 : r_bit + BC_W'(1);
      end
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_START;
               w_bit_nxt   = '0;
               w_idx_nxt   = IDX_LAST;
               w_stop_nxt  = '0;
               w_shift_nxt = s_tx.tx_data;
               w_par_nxt   = f_even_parity(s_tx.tx_data);
            end
         end
         S_START: begin
            if (w_wrap) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = IDX_LAST;
            end
         end
         S_DATA: begin
            if (w_wrap) begin
               if (r_idx == '0) begin
                  w_state_nxt = S_PARITY;
               end else begin
                  w_idx_nxt = r_idx - IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_wrap) begin
               w_state_nxt = S_STOP;
               w_stop_nxt  = '0;
            end
         end
         S_STOP: begin
            if (w_wrap) begin
               if (r_stop == SB_LAST) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_stop_nxt = r_stop + SB_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Line outputs are derived from the next state so the registers line up with it.
   always_comb begin
      w_ser_nxt = 1'b0;
      case (w_state_nxt)
         S_START:  w_ser_nxt = 1'b1;
         S_DATA:   w_ser_nxt = w_shift_nxt[w_idx_nxt];
         S_PARITY: w_ser_nxt = w_par_nxt;
         default:  w_ser_nxt = 1'b0;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_STOP) && (w_bit_nxt == BC_LAST) &&
                   (w_stop_nxt == SB_LAST);
   end

endmodule

// File: tb/tb_bnn_serial_tx.sv
// Bench for bnn_serial_tx: directed frames plus random words, checked clock by
// clock against a field-table model and end to end by an asynchronous receiver.
`timescale 1ns/1ps
module tb_bnn_serial_tx;
   localparam int DW    = 8;
   localparam int BC    = 4;
   localparam int SB    = 1;
   localparam int FRAME = (DW + 2 + SB) * BC;

   logic clk    = 1'b0;
   logic rx_clk = 1'b0;
   logic reset  = 1'b1;
   logic ser_out, ser_busy, tx_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] sent_q[$];
   logic [8:0] rx_q[$];

   bnn_serial_tx_if #(.DATA_W(DW)) u_if ();

   bnn_serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC), .STOP_BITS(SB)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_tx     (u_if),
      .ser_out  (ser_out),
      .ser_busy (ser_busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   // Receiver clock slightly faster than the transmitter so the sample phase drifts.
   initial begin
      #3.3;
      forever #4.9 rx_clk = ~rx_clk;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Expected line value on clock k (1-based) after the handshake.
   function automatic logic exp_ser(input logic [7:0] d, input int k);
      int f;
      f = (k - 1) / BC;
      if (f == 0) return 1'b1;
      if (f <= DW) return d[DW - f];
      if (f == DW + 1) return ^d;
      return 1'b0;
   endfunction

   function automatic logic [8:0] rx_word(input logic [10:0] f);
      return {(f[10] === 1'b1) && (f[1] === ^f[9:2]) && (f[0] === 1'b0), f[9:2]};
   endfunction

   // Model receiver: 3-flop synchronizer, rising-edge start detect, mid-bit sampling.
   logic [2:0]  rx_sync = 3'b000;
   logic        rx_prev = 1'b0;
   logic        rx_act  = 1'b0;
   int          rx_cnt  = 0;
   logic [10:0] rx_bits = '0;

   always @(posedge rx_clk) begin
      rx_sync <= {rx_sync[1:0], ser_out};
      rx_prev <= rx_sync[2];
      if (!rx_act) begin
         if (rx_sync[2] === 1'b1 && rx_prev === 1'b0) begin
            rx_act <= 1'b1;
            rx_cnt <= 1;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt % 4 == 2) rx_bits <= {rx_bits[9:0], rx_sync[2]};
         if (rx_cnt == 42) begin
            rx_act <= 1'b0;
            rx_q.push_back(rx_word({rx_bits[9:0], rx_sync[2]}));
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_handshake(input logic [7:0] d);
      u_if.tx_data  = d;
      u_if.tx_valid = 1'b1;
      chk($sformatf("ready_before_%02h", d), u_if.tx_ready, 1);
      step();
      u_if.tx_valid = 1'b0;
   endtask

   // Called on clock 1 of a frame; ends on the idle clock that follows it.
   task automatic check_frame(input logic [7:0] d, input int junk_clk, input logic [7:0] junk);
      for (int k = 1; k <= FRAME; k++) begin
         if (k == junk_clk) u_if.tx_data = junk;
         chk($sformatf("ser_%02h_c%0d", d, k), ser_out, exp_ser(d, k));
         chk($sformatf("busy_%02h_c%0d", d, k), ser_busy, 1);
         chk($sformatf("done_%02h_c%0d", d, k), tx_done, (k == FRAME));
         chk($sformatf("ready_%02h_c%0d", d, k), u_if.tx_ready, 0);
         step();
      end
      chk($sformatf("idle_ser_%02h", d), ser_out, 0);
      chk($sformatf("idle_ready_%02h", d), u_if.tx_ready, 1);
      chk($sformatf("idle_busy_%02h", d), ser_busy, 0);
      chk($sformatf("idle_done_%02h", d), tx_done, 0);
      sent_q.push_back(d);
   endtask

   task automatic verify_rx();
      int guard;
      guard = 0;
      while (rx_q.size() < sent_q.size() && guard < 200) begin
         step();
         guard++;
      end
      chk("rx_count", rx_q.size(), sent_q.size());
      for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
         chk($sformatf("rx_word_%0d", i), rx_q[i], {1'b1, sent_q[i]});
      rx_q.delete();
      sent_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      int         gap;
      int         bad;

      u_if.tx_valid = 1'b0;
      u_if.tx_data  = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) step();

      // 1: reset held three cycles while idle
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_ser", ser_out, 0);
      chk("rst_busy", ser_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_ready", u_if.tx_ready, 1);
      step();
      chk("rst_ready_after", u_if.tx_ready, 1);

      // 2, 3: single frames
      do_handshake(8'hA5);
      check_frame(8'hA5, 0, 8'h00);
      do_handshake(8'h01);
      check_frame(8'h01, 0, 8'h00);

      // 4: valid held high across two frames
      do_handshake(8'hFF);
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = 8'h00;
      check_frame(8'hFF, 0, 8'h00);
      step();
      u_if.tx_valid = 1'b0;
      check_frame(8'h00, 0, 8'h00);

      // 5: payload changes after latching
      do_handshake(8'hC3);
      check_frame(8'hC3, 10, 8'h00);
      verify_rx();

      // 6: reset on clock 20 aborts the frame
      do_handshake(8'h96);
      for (int k = 1; k < 20; k++) begin
         chk($sformatf("ab_ser_c%0d", k), ser_out, exp_ser(8'h96, k));
         step();
      end
      reset = 1'b1;
      step();
      chk("ab_ser", ser_out, 0);
      chk("ab_ready", u_if.tx_ready, 1);
      chk("ab_busy", ser_busy, 0);
      chk("ab_done", tx_done, 0);
      step();
      reset = 1'b0;
      bad = 0;
      repeat (50) begin
         if (tx_done !== 1'b0 || ser_out !== 1'b0) bad++;
         step();
      end
      chk("ab_quiet", bad, 0);
      rx_q.delete();
      do_handshake(8'h5A);
      check_frame(8'h5A, 0, 8'h00);
      verify_rx();

      // Random words, random gaps, payload scribbled mid-frame
      for (int i = 0; i < 12; i++) begin
         d   = 8'($urandom);
         gap = $urandom_range(0, 3);
         repeat (gap) step();
         do_handshake(d);
         check_frame(d, $urandom_range(1, FRAME), 8'($urandom));
      end
      verify_rx();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
